// File: rtl/monitor_report_collector.sv
// Timestamps automaton report vectors with the symbol index, buffers them in a FIFO and
// keeps sticky hit/overflow state. Optional edge qualification under `MON_RPT_EDGE_EN`.
module monitor_report_collector #(
  parameter int unsigned NUM_REPORTS = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         run_i,
  input  logic                         clear_i,
  input  logic [NUM_REPORTS-1:0]       report_i,
  output logic                         rpt_valid_o,
  input  logic                         rpt_ready_i,
  output logic [NUM_REPORTS+CNT_W-1:0] rpt_data_o,
  output logic [NUM_REPORTS-1:0]       hit_mask_o,
  output logic                         overflow_o,
  output logic [7:0]                   drop_cnt_o,
  output logic                         irq_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = NUM_REPORTS + CNT_W;

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [CNT_W-1:0]       sym_cnt_q, sym_cnt_d;
  logic [NUM_REPORTS-1:0] hit_q, hit_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             drop_q, drop_d;
  logic                   irq_q, irq_d;

  logic [NUM_REPORTS-1:0] qual;
  logic                   capture, pop, push, full;

`ifdef MON_RPT_EDGE_EN
  logic [NUM_REPORTS-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (clear_i) begin
      prev_d = '0;
    end else if (run_i) begin
      prev_d = report_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign qual = report_i & ~prev_q;
`else
  assign qual = report_i;
`endif

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign capture = run_i && (|qual);
  assign pop     = rpt_valid_o && rpt_ready_i;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push    = capture && (!full || pop);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sym_cnt_d = sym_cnt_q;
    hit_d     = hit_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    if (clear_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      sym_cnt_d = '0;
      hit_d     = '0;
      ovf_d     = 1'b0;
      drop_d    = '0;
    end else begin
      if (run_i) begin
        sym_cnt_d = sym_cnt_q + CNT_W'(1);
      end
      if (capture) begin
        hit_d = hit_q | qual;
      end
      if (push) begin
        mem_d[wr_ptr_q] = {qual, sym_cnt_q};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else if (capture) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    irq_d = (count_d != '0) || ovf_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sym_cnt_q <= '0;
      hit_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sym_cnt_q <= sym_cnt_d;
      hit_q     <= hit_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      irq_q     <= irq_d;
    end
  end

  assign rpt_valid_o = (count_q != '0);
  // Head is masked so stale contents never show while the FIFO is empty.
  assign rpt_data_o  = rpt_valid_o ? mem_q[rd_ptr_q] : '0;
  assign hit_mask_o  = hit_q;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;
  assign irq_o       = irq_q;

endmodule
